// File: rtl/axis_mux_n_1_pkt_if.sv
// Stream bundle for the packet-locked N:1 mux: NUM_CH slave channels in, one master stream out.
// The slave modport is the mux view. The master modport is the view of the upstream sources plus the downstream sink.
interface axis_mux_n_1_pkt_if #(
    parameter int DW     = 8,
    parameter int NUM_CH = 4,
    parameter int SELW   = $clog2(NUM_CH)
);
    logic [NUM_CH*DW-1:0] s_tdata;
    logic [NUM_CH-1:0]    s_tvalid;
    logic [NUM_CH-1:0]    s_tlast;
    logic [NUM_CH-1:0]    s_tready;
    logic [DW-1:0]        m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic [SELW-1:0]      m_tsrc;
    logic                 m_tready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tsrc
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tsrc
    );
endinterface

// File: rtl/axis_mux_n_1_pkt.sv
// N:1 AXI-Stream mux that locks one source for a whole packet (fixed select or round-robin).
// The output is registered through a 2-entry skid buffer so back-pressure costs no throughput.
module axis_mux_n_1_pkt #(
    parameter int DW       = 8,
    parameter int NUM_CH   = 4,
    parameter int ARB_MODE = 0,
    parameter int SELW     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SELW-1:0]          sel,
    axis_mux_n_1_pkt_if.slave        axis,
    output logic                     busy
);
    localparam int unsigned NCH_U = NUM_CH;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state, state_d;
    logic [SELW-1:0] grant, grant_d;
    logic [SELW-1:0] rr_last, rr_last_d;

    logic            out_valid, out_last;
    logic [DW-1:0]   out_data;
    logic [SELW-1:0] out_src;
    logic            skid_valid, skid_last;
    logic [DW-1:0]   skid_data;
    logic [SELW-1:0] skid_src;

    logic            accept;
    logic            in_last;
    logic [DW-1:0]   in_data;

    assign in_data = axis.s_tdata[int'(grant)*DW +: DW];
    assign in_last = axis.s_tlast[grant];
    // Ready depends only on registered state. Holding it low while the skid is full keeps the buffer from overflowing.
    assign accept  = (state == LOCK) && axis.s_tvalid[grant] && !skid_valid;

    always_comb begin
        axis.s_tready = '0;
        if (state == LOCK && !skid_valid) begin
            axis.s_tready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= '0;
            rr_last <= SELW'(NUM_CH - 1);
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            rr_last <= rr_last_d;
        end
    end

    always_comb begin
        int unsigned idx;
        logic        found;
        state_d   = state;
        grant_d   = grant;
        rr_last_d = rr_last;
        idx       = 0;
        found     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ARB_MODE == 0) begin
                    // An out-of-range sel matches no channel and is treated as no request.
                    for (int unsigned i = 0; i < NCH_U; i++) begin
                        if (sel == SELW'(i) && axis.s_tvalid[SELW'(i)]) begin
                            grant_d = SELW'(i);
                            state_d = LOCK;
                        end
                    end
                end else begin
                    for (int unsigned k = 1; k <= NCH_U; k++) begin
                        idx = (32'(rr_last) + k) % NCH_U;
                        if (!found && axis.s_tvalid[SELW'(idx)]) begin
                            found   = 1'b1;
                            grant_d = SELW'(idx);
                            state_d = LOCK;
                        end
                    end
                end
            end
            LOCK: begin
                if (accept && in_last) begin
                    state_d   = IDLE;
                    rr_last_d = grant;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            skid_src   <= '0;
        end else if (accept) begin
            // The skid is always empty on accept. A beat lands in the out reg unless that reg is stalled.
            if (!out_valid || axis.m_tready) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_last  <= in_last;
                out_src   <= grant;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_last  <= in_last;
                skid_src   <= grant;
            end
        end else if (out_valid && axis.m_tready) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_last   <= skid_last;
                out_src    <= skid_src;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign axis.m_tvalid = out_valid;
    assign axis.m_tdata  = out_data;
    assign axis.m_tlast  = out_last;
    assign axis.m_tsrc   = out_src;
    assign busy          = (state == LOCK);
endmodule

// File: tb/tb_axis_mux_n_1_pkt.sv
// Directed bench for axis_mux_n_1_pkt: one fixed-select instance and one round-robin instance.
// Both instances share the clock and reset.
module tb_axis_mux_n_1_pkt;
    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam int SW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [SW-1:0] sel0, sel1;
    logic          busy0, busy1;

    axis_mux_n_1_pkt_if #(.DW(DW), .NUM_CH(NCH)) if0 ();
    axis_mux_n_1_pkt_if #(.DW(DW), .NUM_CH(NCH)) if1 ();

    axis_mux_n_1_pkt #(.DW(DW), .NUM_CH(NCH), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .sel(sel0), .axis(if0.slave), .busy(busy0));
    axis_mux_n_1_pkt #(.DW(DW), .NUM_CH(NCH), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .sel(sel1), .axis(if1.slave), .busy(busy1));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [8:0] src_mem [NCH][16];
    int         src_len [NCH];
    int         src_ptr [NCH];
    bit         dsel;
    logic       mrdy;

    logic [7:0] out_d [64];
    logic       out_l [64];
    logic [1:0] out_s [64];
    int         out_c [64];
    int         out_n = 0;

    logic       prev_mv, prev_mr, prev_ml, prev_hs;
    logic [7:0] prev_md;
    logic [1:0] prev_ms;
    logic [3:0] prev_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [7:0] d, input logic l);
        src_mem[c][src_len[c]] = {l, d};
        src_len[c]++;
    endtask

    task automatic drive_inputs();
        logic [NCH*DW-1:0] d;
        logic [NCH-1:0]    v, l;
        d = '0; v = '0; l = '0;
        for (int c = 0; c < NCH; c++) begin
            if (src_ptr[c] < src_len[c]) begin
                v[c] = 1'b1;
                d[c*DW +: DW] = src_mem[c][src_ptr[c]][7:0];
                l[c] = src_mem[c][src_ptr[c]][8];
            end
        end
        if (dsel) begin
            if1.s_tdata = d; if1.s_tvalid = v; if1.s_tlast = l; if1.m_tready = mrdy;
            if0.s_tdata = '0; if0.s_tvalid = '0; if0.s_tlast = '0; if0.m_tready = 1'b1;
        end else begin
            if0.s_tdata = d; if0.s_tvalid = v; if0.s_tlast = l; if0.m_tready = mrdy;
            if1.s_tdata = '0; if1.s_tvalid = '0; if1.s_tlast = '0; if1.m_tready = 1'b1;
        end
    endtask

    task automatic read_out(output logic mv, output logic [7:0] md, output logic ml,
                            output logic [1:0] ms, output logic [3:0] sr);
        if (dsel) begin
            mv = if1.m_tvalid; md = if1.m_tdata; ml = if1.m_tlast; ms = if1.m_tsrc; sr = if1.s_tready;
        end else begin
            mv = if0.m_tvalid; md = if0.m_tdata; ml = if0.m_tlast; ms = if0.m_tsrc; sr = if0.s_tready;
        end
    endtask

    // One clock cycle: account for the handshakes of the edge just passed, check the AXI hold rules, drive the next inputs.
    task automatic step();
        logic mv, ml;
        logic [7:0] md;
        logic [1:0] ms;
        logic [3:0] sr;
        @(negedge clk);
        cyc++;
        for (int c = 0; c < NCH; c++) if (prev_acc[c]) src_ptr[c]++;
        if (prev_hs && out_n < 64) begin
            out_d[out_n] = prev_md; out_l[out_n] = prev_ml; out_s[out_n] = prev_ms;
            out_c[out_n] = cyc; out_n++;
        end
        read_out(mv, md, ml, ms, sr);
        if (prev_mv && !prev_mr)
            check("hold", {mv, ml, ms, md}, {1'b1, prev_ml, prev_ms, prev_md});
        if (prev_mv && !prev_mr && prev_acc != 0)
            check("skid_rdy", 32'(sr), 32'd0);
        drive_inputs();
        #1;
        read_out(mv, md, ml, ms, sr);
        prev_mv = mv; prev_md = md; prev_ml = ml; prev_ms = ms; prev_mr = mrdy;
        prev_acc = sr & (dsel ? if1.s_tvalid : if0.s_tvalid);
        prev_hs = mv && mrdy;
    endtask

    task automatic clear_state();
        for (int c = 0; c < NCH; c++) begin
            src_len[c] = 0;
            src_ptr[c] = 0;
        end
        prev_mv = 0; prev_mr = 0; prev_ml = 0; prev_hs = 0; prev_md = '0; prev_ms = '0; prev_acc = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_state();
        drive_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic expect_beat(input string tag, input int i, input logic [7:0] d,
                               input logic l, input logic [1:0] s);
        check(tag, {out_s[i], out_l[i], out_d[i]}, {s, l, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        logic rdy1;
        logic [7:0] t3_d [10];
        logic [1:0] t3_s [10];
        t3_d = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h08, 8'h09};
        t3_s = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        sel0 = '0; sel1 = '0; dsel = 1'b1; mrdy = 1'b1;
        clear_state();

        // 1: reset with every channel requesting, then release latency
        rst = 1'b0;
        push(0, 8'h55, 1'b0); push(0, 8'h56, 1'b0);
        push(1, 8'h15, 1'b0); push(2, 8'h25, 1'b0); push(3, 8'h35, 1'b0);
        drive_inputs();
        step(); step();
        check("rst_mvalid", 32'(if1.m_tvalid), 32'd0);
        check("rst_mdata", 32'(if1.m_tdata), 32'd0);
        check("rst_mlast_src", {if1.m_tlast, if1.m_tsrc}, 32'd0);
        check("rst_srdy", 32'(if1.s_tready), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_dut0", {if0.m_tvalid, if0.m_tdata, if0.s_tready, busy0}, 32'd0);
        rst = 1'b1;
        step();
        check("rel_c1_mvalid", 32'(if1.m_tvalid), 32'd0);
        check("rel_c1_busy", 32'(busy1), 32'd1);
        step();
        check("rel_c2_beat", {if1.m_tvalid, if1.m_tsrc, if1.m_tdata}, {1'b1, 2'd0, 8'h55});
        do_reset();

        // 2: fixed select on ch2, sel moves to 1 mid-packet
        dsel = 1'b0; sel0 = 2'd2; mrdy = 1'b1; rdy1 = 1'b0;
        for (int i = 0; i < 4; i++) push(2, 8'(160 + i), i == 3);
        push(1, 8'hB0, 1'b1);
        drive_inputs();
        b = out_n;
        for (int k = 0; k < 40 && out_n < b + 5; k++) begin
            step();
            if (src_ptr[2] >= 1) sel0 = 2'd1;
            if (src_ptr[2] < 4) rdy1 = rdy1 | if0.s_tready[1];
        end
        check("t2_count", out_n, b + 5);
        for (int i = 0; i < 4; i++) expect_beat("t2_beat", b + i, 8'(160 + i), i == 3, 2'd2);
        for (int i = 1; i < 4; i++) check("t2_gap", out_c[b+i] - out_c[b+i-1], 1);
        expect_beat("t2_next_pkt", b + 4, 8'hB0, 1'b1, 2'd1);
        check("t2_bubble", out_c[b+4] - out_c[b+3], 2);
        check("t2_rdy1_low", 32'(rdy1), 32'd0);

        // 3: round-robin across four busy channels
        dsel = 1'b1;
        do_reset();
        push(0, 8'h00, 1'b0); push(0, 8'h01, 1'b1); push(0, 8'h08, 1'b0); push(0, 8'h09, 1'b1);
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1);
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
        drive_inputs();
        b = out_n;
        for (int k = 0; k < 60 && out_n < b + 10; k++) step();
        check("t3_count", out_n, b + 10);
        for (int i = 0; i < 10; i++) expect_beat("t3_beat", b + i, t3_d[i], i % 2 == 1, t3_s[i]);
        for (int i = 1; i < 10; i++) check("t3_gap", out_c[b+i] - out_c[b+i-1], (i % 2 == 1) ? 1 : 2);

        // 4: back-pressure with m_tready pattern 1,0,0
        do_reset();
        for (int i = 0; i < 8; i++) push(1, 8'(64 + i), i == 7);
        drive_inputs();
        b = out_n;
        for (int k = 0; k < 80 && out_n < b + 8; k++) begin
            mrdy = (k % 3 == 0);
            step();
        end
        mrdy = 1'b1;
        check("t4_count", out_n, b + 8);
        for (int i = 0; i < 8; i++) expect_beat("t4_beat", b + i, 8'(64 + i), i == 7, 2'd1);
        step(); step();

        // 5: reset mid-packet, then arbitration restarts from ch0
        for (int i = 0; i < 5; i++) push(2, 8'(96 + i), i == 4);
        drive_inputs();
        for (int k = 0; k < 20 && src_ptr[2] < 2; k++) step();
        check("t5_two_accepted", src_ptr[2], 2);
        rst = 1'b0;
        #1;
        check("t5_rst_mvalid", 32'(if1.m_tvalid), 32'd0);
        check("t5_rst_busy", 32'(busy1), 32'd0);
        do_reset();
        push(2, 8'h71, 1'b1);
        push(0, 8'h70, 1'b1);
        drive_inputs();
        b = out_n;
        for (int k = 0; k < 30 && out_n < b + 2; k++) step();
        repeat (4) step();
        check("t5_count", out_n, b + 2);
        expect_beat("t5_first_ch0", b, 8'h70, 1'b1, 2'd0);
        expect_beat("t5_then_ch2", b + 1, 8'h71, 1'b1, 2'd2);

        // 6: back-to-back single-beat packets on ch3
        for (int i = 0; i < 4; i++) push(3, 8'(128 + i), 1'b1);
        drive_inputs();
        b = out_n;
        for (int k = 0; k < 40 && out_n < b + 4; k++) step();
        check("t6_count", out_n, b + 4);
        for (int i = 0; i < 4; i++) expect_beat("t6_beat", b + i, 8'(128 + i), 1'b1, 2'd3);
        for (int i = 1; i < 4; i++) check("t6_gap", out_c[b+i] - out_c[b+i-1], 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
